// File: rtl/twf_mul_seq.sv
// -----------------------------------------------------------------------------
// twf_mul_seq
//   Consumer side of the 16-lane twiddle ROM interface. For every accepted
//   16-sample beat it drives a group index to an external twiddle ROM. It takes
//   the twiddles the ROM returns one cycle later and multiplies each complex lane
//   by its twiddle. The result is rounded half-up back to DW bits. The block is
//   fully pipelined with a fixed latency of two cycles and no backpressure.
//
// Build option:
//   TWF_SAT_EN  defined   -> results that do not fit in DW bits clamp to the
//                            nearest bound and set the sticky sat_flag.
//               undefined -> results keep their low DW bits (two's-complement
//                            wrap) and sat_flag is tied to 0.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high; clears every register
//   in_valid   input beat valid
//   in_sop     first beat of a frame (qualified by in_valid)
//   in_re/im   16 input lanes, DW-bit signed
//   grp_idx    group index to the twiddle ROM (combinational)
//   tw_re/im   16 ROM twiddles, TW-bit signed Q2.(FRAC); valid one cycle
//              after grp_idx
//   out_valid  output beat valid
//   out_sop    output beat is the first beat of a frame
//   out_eop    output beat is group NGRP-1
//   out_re/im  16 product lanes, DW-bit signed; hold while out_valid=0
//   frame_err  sticky: a frame was restarted before it completed
//   sat_flag   sticky: a product was clamped (TWF_SAT_EN builds only)
// -----------------------------------------------------------------------------
module twf_mul_seq #(
    parameter int DW   = 13,
    parameter int TW   = 9,
    parameter int FRAC = 7,
    parameter int NGRP = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_sop,
    input  logic [15:0][DW-1:0]           in_re,
    input  logic [15:0][DW-1:0]           in_im,
    output logic [$clog2(NGRP)-1:0]       grp_idx,
    input  logic [15:0][TW-1:0]           tw_re,
    input  logic [15:0][TW-1:0]           tw_im,
    output logic                          out_valid,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [15:0][DW-1:0]           out_re,
    output logic [15:0][DW-1:0]           out_im,
    output logic                          frame_err,
    output logic                          sat_flag
);

    localparam int LANES = 16;
    localparam int GW    = $clog2(NGRP);
    // Full-precision width of a complex product term sum.
    localparam int PW    = DW + TW + 1;

    // Group counter and frame tracking
    logic [GW-1:0] grp_cnt_q, grp_cnt_d;
    logic          frame_err_q, frame_err_d;

    // Stage 1 registers: input beat aligned with the ROM output
    logic                   vld_p1_q, vld_p1_d;
    logic                   sop_p1_q, sop_p1_d;
    logic                   eop_p1_q, eop_p1_d;
    logic [LANES-1:0][DW-1:0] re_p1_q, re_p1_d;
    logic [LANES-1:0][DW-1:0] im_p1_q, im_p1_d;

    // Stage 2 registers: rounded products
    logic                   vld_p2_q, vld_p2_d;
    logic                   sop_p2_q, sop_p2_d;
    logic                   eop_p2_q, eop_p2_d;
    logic [LANES-1:0][DW-1:0] re_p2_q, re_p2_d;
    logic [LANES-1:0][DW-1:0] im_p2_q, im_p2_d;

    // Per-lane arithmetic between stage 1 and stage 2
    logic signed [PW-1:0] a_re [LANES];
    logic signed [PW-1:0] a_im [LANES];
    logic signed [PW-1:0] w_re [LANES];
    logic signed [PW-1:0] w_im [LANES];
    logic signed [PW-1:0] p_re [LANES];
    logic signed [PW-1:0] p_im [LANES];
    logic signed [PW-1:0] r_re [LANES];
    logic signed [PW-1:0] r_im [LANES];

    // Round half-up: add one half LSB of the result, then drop FRAC bits.
    function automatic logic signed [PW-1:0] round_half_up(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] half;
        logic signed [PW-1:0] sum;
        half = '0;
        half[FRAC-1] = 1'b1;
        sum = v + half;
        return sum >>> FRAC;
    endfunction

`ifdef TWF_SAT_EN
    localparam logic signed [PW-1:0] MAXV = PW'((1 << (DW - 1)) - 1);
    localparam logic signed [PW-1:0] MINV = PW'(-(1 << (DW - 1)));

    function automatic logic out_of_range(input logic signed [PW-1:0] v);
        return (v > MAXV) || (v < MINV);
    endfunction

    function automatic logic [DW-1:0] reduce(input logic signed [PW-1:0] v);
        if (v > MAXV) begin
            return DW'(MAXV);
        end
        if (v < MINV) begin
            return DW'(MINV);
        end
        return DW'(v);
    endfunction
`else
    function automatic logic [DW-1:0] reduce(input logic signed [PW-1:0] v);
        return DW'(v);
    endfunction
`endif

    // A sop restarts the frame at group 0 regardless of the running count.
    assign grp_idx = (in_valid && in_sop) ? '0 : grp_cnt_q;

    always_comb begin
        grp_cnt_d = grp_cnt_q;
        if (in_valid) begin
            grp_cnt_d = (grp_idx == GW'(NGRP - 1)) ? '0 : grp_idx + GW'(1);
        end
        // A sop that lands on a nonzero count means the previous frame was cut.
        frame_err_d = frame_err_q | (in_valid & in_sop & (grp_cnt_q != '0));

        vld_p1_d = in_valid;
        sop_p1_d = in_valid & in_sop;
        eop_p1_d = in_valid & (grp_idx == GW'(NGRP - 1));
        re_p1_d  = in_re;
        im_p1_d  = in_im;
    end

    // ---- stage 1 -> stage 2 boundary: complex multiply per lane ----
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            a_re[l] = PW'($signed(re_p1_q[l]));
            a_im[l] = PW'($signed(im_p1_q[l]));
            w_re[l] = PW'($signed(tw_re[l]));
            w_im[l] = PW'($signed(tw_im[l]));
            p_re[l] = a_re[l] * w_re[l] - a_im[l] * w_im[l];
            p_im[l] = a_re[l] * w_im[l] + a_im[l] * w_re[l];
            r_re[l] = round_half_up(p_re[l]);
            r_im[l] = round_half_up(p_im[l]);
        end
    end

    always_comb begin
        vld_p2_d = vld_p1_q;
        sop_p2_d = sop_p2_q;
        eop_p2_d = eop_p2_q;
        re_p2_d  = re_p2_q;
        im_p2_d  = im_p2_q;
        // Outputs only move on a valid beat; otherwise they hold.
        if (vld_p1_q) begin
            sop_p2_d = sop_p1_q;
            eop_p2_d = eop_p1_q;
            for (int l = 0; l < LANES; l++) begin
                re_p2_d[l] = reduce(r_re[l]);
                im_p2_d[l] = reduce(r_im[l]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grp_cnt_q   <= '0;
            frame_err_q <= 1'b0;
            vld_p1_q    <= 1'b0;
            sop_p1_q    <= 1'b0;
            eop_p1_q    <= 1'b0;
            re_p1_q     <= '0;
            im_p1_q     <= '0;
            vld_p2_q    <= 1'b0;
            sop_p2_q    <= 1'b0;
            eop_p2_q    <= 1'b0;
            re_p2_q     <= '0;
            im_p2_q     <= '0;
        end else begin
            grp_cnt_q   <= grp_cnt_d;
            frame_err_q <= frame_err_d;
            vld_p1_q    <= vld_p1_d;
            sop_p1_q    <= sop_p1_d;
            eop_p1_q    <= eop_p1_d;
            re_p1_q     <= re_p1_d;
            im_p1_q     <= im_p1_d;
            vld_p2_q    <= vld_p2_d;
            sop_p2_q    <= sop_p2_d;
            eop_p2_q    <= eop_p2_d;
            re_p2_q     <= re_p2_d;
            im_p2_q     <= im_p2_d;
        end
    end

`ifdef TWF_SAT_EN
    logic [LANES-1:0] lane_ovf;
    logic             sat_flag_q, sat_flag_d;

    always_comb begin
        lane_ovf = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_ovf[l] = out_of_range(r_re[l]) | out_of_range(r_im[l]);
        end
        sat_flag_d = sat_flag_q | (vld_p1_q & (|lane_ovf));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag_q <= 1'b0;
        end else begin
            sat_flag_q <= sat_flag_d;
        end
    end

    assign sat_flag = sat_flag_q;
`else
    assign sat_flag = 1'b0;
`endif

    assign out_valid = vld_p2_q;
    assign out_sop   = sop_p2_q;
    assign out_eop   = eop_p2_q;
    assign out_re    = re_p2_q;
    assign out_im    = im_p2_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_twf_mul_seq.sv
module tb_twf_mul_seq;

    localparam int DW    = 13;
    localparam int TW    = 9;
    localparam int NGRP  = 32;
    localparam int LANES = 16;
    localparam int NVEC  = 7;

`ifdef TWF_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_sop;
    logic [LANES-1:0][DW-1:0] in_re;
    logic [LANES-1:0][DW-1:0] in_im;
    logic [4:0]               grp_idx;
    logic [LANES-1:0][TW-1:0] tw_re;
    logic [LANES-1:0][TW-1:0] tw_im;
    logic [LANES-1:0][TW-1:0] tw_nx_re;
    logic [LANES-1:0][TW-1:0] tw_nx_im;
    logic                     out_valid;
    logic                     out_sop;
    logic                     out_eop;
    logic [LANES-1:0][DW-1:0] out_re;
    logic [LANES-1:0][DW-1:0] out_im;
    logic                     frame_err;
    logic                     sat_flag;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int are;
        int aim;
        int wre;
        int wim;
        int ere;
        int eim;
    } vec_t;

    vec_t tbl [NVEC];

    // Expected-output model for the sequencing tests (stage 1 and output stage)
    logic m1_v, m1_sop, m1_eop;
    int   m1_r0, m1_r15, m1_i0;
    logic mo_v, mo_sop, mo_eop;
    int   mo_r0, mo_r15, mo_i0;

    twf_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_re     (in_re),
        .in_im     (in_im),
        .grp_idx   (grp_idx),
        .tw_re     (tw_re),
        .tw_im     (tw_im),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_re    (out_re),
        .out_im    (out_im),
        .frame_err (frame_err),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    // Stand-in for the registered twiddle ROM: values presented with a beat
    // appear on tw_re/tw_im one cycle later.
    always @(posedge clk) begin
        tw_re <= tw_nx_re;
        tw_im <= tw_nx_im;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle of the sequencing tests with unity twiddles.
    // Called at a negedge; returns at the next negedge after checking outputs.
    task automatic step(input logic rs, input logic v, input logic s,
                        input int val, input int exp_grp, input string tag);
        rst      = rs;
        in_valid = v;
        in_sop   = s;
        for (int l = 0; l < LANES; l++) begin
            in_re[l]    = DW'(val + l);
            in_im[l]    = DW'(-val);
            tw_nx_re[l] = TW'(128);
            tw_nx_im[l] = TW'(0);
        end
        #1;
        if (!rs) begin
            check({tag, " grp_idx"}, int'(grp_idx), exp_grp);
        end
        @(posedge clk);
        if (rs) begin
            m1_v = 0; m1_sop = 0; m1_eop = 0; m1_r0 = 0; m1_r15 = 0; m1_i0 = 0;
            mo_v = 0; mo_sop = 0; mo_eop = 0; mo_r0 = 0; mo_r15 = 0; mo_i0 = 0;
        end else begin
            if (m1_v) begin
                mo_sop = m1_sop;
                mo_eop = m1_eop;
                mo_r0  = m1_r0;
                mo_r15 = m1_r15;
                mo_i0  = m1_i0;
            end
            mo_v   = m1_v;
            m1_v   = v;
            m1_sop = v & s;
            m1_eop = v && (exp_grp == NGRP - 1);
            m1_r0  = val;
            m1_r15 = val + 15;
            m1_i0  = -val;
        end
        @(negedge clk);
        check({tag, " out_valid"}, int'(out_valid), int'(mo_v));
        check({tag, " out_sop"}, int'(out_sop), int'(mo_sop));
        check({tag, " out_eop"}, int'(out_eop), int'(mo_eop));
        check({tag, " out_re0"}, int'($signed(out_re[0])), mo_r0);
        check({tag, " out_re15"}, int'($signed(out_re[15])), mo_r15);
        check({tag, " out_im0"}, int'($signed(out_im[0])), mo_i0);
    endtask

    initial begin
        int k;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_re    = '0;
        in_im    = '0;
        tw_nx_re = '0;
        tw_nx_im = '0;
        m1_v = 0; m1_sop = 0; m1_eop = 0; m1_r0 = 0; m1_r15 = 0; m1_i0 = 0;
        mo_v = 0; mo_sop = 0; mo_eop = 0; mo_r0 = 0; mo_r15 = 0; mo_i0 = 0;

        //              a_re   a_im   w_re  w_im  exp_re               exp_im
        tbl[0] = '{ 100,   -37,   128,    0,  100,                 -37};
        tbl[1] = '{  50,    20,     0, -128,   20,                 -50};
        tbl[2] = '{   3,    -3,    64,    0,    2,                  -1};
        tbl[3] = '{-4096,    0,  -256,    0,  SAT ? 4095 : 0,        0};
        tbl[4] = '{4095,  4095,   127,  127,    0, SAT ? 4095 : -66};
        tbl[5] = '{  -1,     1,    64,   64,   -1,                   0};
        tbl[6] = '{4095,     0,  -256,    0,  SAT ? -4096 : 2,       0};

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_sop", int'(out_sop), 0);
        check("rst out_eop", int'(out_eop), 0);
        check("rst out_re0", int'($signed(out_re[0])), 0);
        check("rst out_im9", int'($signed(out_im[9])), 0);
        check("rst frame_err", int'(frame_err), 0);
        check("rst sat_flag", int'(sat_flag), 0);
        check("rst grp_idx", int'(grp_idx), 0);
        rst = 1'b0;

        // Table vectors, back to back; lane l of beat r uses record (r+l)%NVEC
        for (int r = 0; r < NVEC + 2; r++) begin
            if (r >= 2) begin
                check($sformatf("tbl beat%0d out_valid", r - 2), int'(out_valid), 1);
                for (int l = 0; l < LANES; l++) begin
                    k = (r - 2 + l) % NVEC;
                    check($sformatf("tbl beat%0d lane%0d re", r - 2, l),
                          int'($signed(out_re[l])), tbl[k].ere);
                    check($sformatf("tbl beat%0d lane%0d im", r - 2, l),
                          int'($signed(out_im[l])), tbl[k].eim);
                end
            end else begin
                check($sformatf("tbl latency out_valid c%0d", r), int'(out_valid), 0);
            end
            if (r < NVEC) begin
                in_valid = 1'b1;
                in_sop   = 1'b0;
                for (int l = 0; l < LANES; l++) begin
                    k = (r + l) % NVEC;
                    in_re[l]    = DW'(tbl[k].are);
                    in_im[l]    = DW'(tbl[k].aim);
                    tw_nx_re[l] = TW'(tbl[k].wre);
                    tw_nx_im[l] = TW'(tbl[k].wim);
                end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("tbl sat_flag", int'(sat_flag), int'(SAT));

        // Full frame with sop, three gap cycles mid-frame, then wrap
        step(1'b1, 1'b0, 1'b0, 0, 0, "rst_a");
        check("rst_a frame_err", int'(frame_err), 0);
        check("rst_a sat_flag", int'(sat_flag), 0);
        step(1'b0, 1'b1, 1'b1, -40, 0, "f1");
        for (int g = 1; g < 16; g++) step(1'b0, 1'b1, 1'b0, -40 + 3 * g, g, "f1");
        for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b0, 0, 16, "gap");
        for (int g = 16; g < NGRP; g++) step(1'b0, 1'b1, 1'b0, -40 + 3 * g, g, "f1");
        // Second frame without sop starts again at group 0
        for (int g = 0; g < 10; g++) step(1'b0, 1'b1, 1'b0, 7 * g, g, "f2");
        check("wrap frame_err", int'(frame_err), 0);

        // Mid-frame restart at grp_cnt=10
        step(1'b0, 1'b1, 1'b1, 500, 0, "restart");
        check("restart frame_err", int'(frame_err), 1);
        step(1'b0, 1'b0, 1'b0, 0, 1, "idle");
        step(1'b0, 1'b0, 1'b0, 0, 1, "idle");
        check("restart frame_err sticky", int'(frame_err), 1);

        // Reset with beats in flight
        step(1'b0, 1'b1, 1'b0, 11, 1, "pre_rst");
        step(1'b0, 1'b1, 1'b0, 12, 2, "pre_rst");
        step(1'b1, 1'b0, 1'b0, 0, 0, "rst_b");
        check("rst_b frame_err", int'(frame_err), 0);
        check("rst_b sat_flag", int'(sat_flag), 0);
        check("rst_b out_im7", int'($signed(out_im[7])), 0);
        step(1'b0, 1'b0, 1'b0, 0, 0, "post_rst");
        step(1'b0, 1'b1, 1'b0, 33, 0, "post_rst");
        step(1'b0, 1'b0, 1'b0, 0, 1, "drain");
        step(1'b0, 1'b0, 1'b0, 0, 1, "drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
